// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 block store: rows in raster order, beats out in JPEG zigzag order.
// Block N+1 loads into the idle bank while block N drains.
module zigzag_buffer #(
    parameter int W_IO = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0][W_IO-1:0] in_data,
    input  logic                 in_sob,
    input  logic                 in_eob,
    input  logic                 in_sof,
    output logic                 out_valid,
    output logic [7:0][W_IO-1:0] out_data,
    output logic                 out_sob,
    output logic                 out_eob,
    output logic                 out_sof,
    output logic                 err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    // Natural index (8r+c) for each zigzag position.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [7:0][W_IO-1:0] mem [2][8];
    logic [7:0][W_IO-1:0] beat_data;

    logic [1:0] full;
    logic [1:0] sof_tag;
    logic       sof_pend;
    logic       wsel;
    logic [2:0] wrow;
    logic       rsel;
    logic [2:0] rcnt;
    logic [0:0] state;

    logic drain_last;
    logic ovf;
    logic drop;
    logic wr_en;
    logic close;
    logic nxt_full;
    logic sob_unused;

    assign sob_unused = in_sob;

    assign drain_last = (state == DRAIN) && (rcnt == 3'd7);
    // A bank emptied by this cycle's final beat may take a new row now.
    assign ovf   = full[wsel] && !(drain_last && (rsel == wsel));
    assign drop  = (wrow == 3'd7) && !in_eob;
    assign wr_en = in_valid && !ovf && !drop;
    assign close = wr_en && in_eob;
    // Include a same-cycle close so back-to-back blocks drain without a gap.
    assign nxt_full = full[~rsel] || (close && (wsel != rsel));

    always_comb begin
        beat_data = '0;
        for (int j = 0; j < 8; j++) begin
            beat_data[j] = mem[rsel][ZZ[{rcnt, 3'(j)}][5:3]][ZZ[{rcnt, 3'(j)}][2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wsel][wrow] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            sof_tag   <= '0;
            sof_pend  <= 1'b0;
            wsel      <= 1'b0;
            wrow      <= '0;
            rsel      <= 1'b0;
            rcnt      <= '0;
            state     <= IDLE;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_valid && (ovf || drop)) begin
                err <= 1'b1;
            end
            if (close && (wrow != 3'd7)) begin
                err <= 1'b1;
            end
            if (wr_en) begin
                if (wrow == 3'd0) begin
                    sof_pend <= in_sof;
                end
                if (in_eob) begin
                    wsel <= ~wsel;
                    wrow <= '0;
                end else begin
                    wrow <= wrow + 3'd1;
                end
            end
            if (drain_last) begin
                full[rsel] <= 1'b0;
            end
            if (close) begin
                full[wsel]    <= 1'b1;
                sof_tag[wsel] <= (wrow == 3'd0) ? in_sof : sof_pend;
            end

            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (full[rsel]) begin
                        state <= DRAIN;
                        rcnt  <= '0;
                    end
                end
                DRAIN: begin
                    out_valid <= 1'b1;
                    out_sob   <= (rcnt == 3'd0);
                    out_eob   <= (rcnt == 3'd7);
                    out_sof   <= sof_tag[rsel] && (rcnt == 3'd0);
                    out_data  <= beat_data;
                    rcnt      <= rcnt + 3'd1;
                    if (rcnt == 3'd7) begin
                        rsel  <= ~rsel;
                        state <= nxt_full ? DRAIN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed bench for zigzag_buffer: scoreboard of expected zigzag beats
// built from an independent diagonal-walk order and a shadow of bank contents.
module tb_zigzag_buffer;

    localparam int W = 16;

    typedef struct {
        logic [7:0][W-1:0] d;
        logic              sob;
        logic              eob;
        logic              sof;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0][W-1:0] in_data = '0;
    logic              in_sob = 1'b0;
    logic              in_eob = 1'b0;
    logic              in_sof = 1'b0;
    logic              out_valid;
    logic [7:0][W-1:0] out_data;
    logic              out_sob;
    logic              out_eob;
    logic              out_sof;
    logic              err;

    zigzag_buffer #(.W_IO(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sob   (in_sob),
        .in_eob   (in_eob),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sob  (out_sob),
        .out_eob  (out_eob),
        .out_sof  (out_sof),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int                zz [64];
    logic [7:0][W-1:0] mb [2][8];
    int                mw = 0;
    int                mrow = 0;
    bit                msof = 1'b0;
    bit                exp_err = 1'b0;
    int                eob_cyc = 0;
    beat_t             expq [$];

    int                nbeats = 0;
    int                b0q [$];
    int                b7_cyc = 0;
    logic [7:0][W-1:0] b0_data;
    logic [7:0][W-1:0] b7_data;

    function automatic logic [7:0][W-1:0] mkrow(input int base, input int r);
        logic [7:0][W-1:0] v;
        for (int c = 0; c < 8; c++) v[c] = W'(base + 8 * r + c);
        return v;
    endfunction

    task automatic push_block();
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                b.d[j] = mb[mw][zz[8*k+j] / 8][zz[8*k+j] % 8];
            end
            b.sob = (k == 0);
            b.eob = (k == 7);
            b.sof = msof && (k == 0);
            expq.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0][W-1:0] d, input bit sob,
                        input bit eob, input bit sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
        if (mrow == 7 && !eob) begin
            exp_err = 1'b1;
        end else begin
            mb[mw][mrow] = d;
            if (mrow == 0) msof = sof;
            if (eob) begin
                if (mrow != 7) exp_err = 1'b1;
                push_block();
                mw      = 1 - mw;
                mrow    = 0;
                eob_cyc = cyc + 1;
            end else begin
                mrow++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sob   = 1'b0;
            in_eob   = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_block(input int base, input bit sof);
        for (int r = 0; r < 8; r++) send(mkrow(base, r), r == 0, r == 7, sof && r == 0);
    endtask

    task automatic model_reset();
        expq.delete();
        mw      = 0;
        mrow    = 0;
        exp_err = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_flags"}, {out_sob, out_eob, out_sof}, 3'b000);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_eob   = 1'b0;
        rst      = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i;
        i = 0;
        while (expq.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_drained"}, expq.size(), 0);
        idle(2);
        chk({tag, "_err"}, err, exp_err);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                beat_t e;
                nbeats++;
                if (out_sob) begin
                    b0q.push_back(cyc);
                    b0_data = out_data;
                end
                if (out_eob) begin
                    b7_cyc  = cyc;
                    b7_data = out_data;
                end
                if (expq.size() == 0) begin
                    chk("spurious_beat", out_valid, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_flags", {out_sob, out_eob, out_sof}, {e.sob, e.eob, e.sof});
                end
            end else begin
                chk("idle_flags", {out_sob, out_eob}, 2'b00);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                e0 [8];
        int                e7 [8];
        logic [7:0][W-1:0] x0;
        logic [7:0][W-1:0] x7;
        int                t1;
        int                nb;
        int                p;
        int                lo;
        int                hi;
        int                w;

        e0 = '{0, 1, 8, 16, 9, 2, 3, 10};
        e7 = '{53, 60, 61, 54, 47, 55, 62, 63};
        for (int j = 0; j < 8; j++) begin
            x0[j] = W'(e0[j]);
            x7[j] = W'(e7[j]);
        end

        p = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[p] = 8 * r + (s - r); p++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[p] = 8 * r + (s - r); p++; end
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outs("por");
        rst = 1'b0;
        idle(2);

        // Single block, natural values
        b0q.delete();
        send_block(0, 1'b1);
        t1 = eob_cyc;
        idle(1);
        wait_drain("single", 40);
        chk("single_b0_lat", (b0q.size() > 0) ? b0q[0] - t1 : -1, 2);
        chk("single_b7_lat", b7_cyc - t1, 9);
        chk("single_b0_lanes", b0_data, x0);
        chk("single_b7_lanes", b7_data, x7);

        // Four blocks back-to-back
        b0q.delete();
        nb = nbeats;
        for (int b = 0; b < 4; b++) send_block(64 * b, b == 0);
        idle(1);
        wait_drain("b2b", 80);
        chk("b2b_blocks", b0q.size(), 4);
        chk("b2b_span", (b0q.size() > 0) ? b7_cyc - b0q[0] : -1, 31);
        chk("b2b_beats", nbeats - nb, 32);

        // Short block: eob on row 5
        for (int r = 0; r < 6; r++) send(mkrow(300, r), r == 0, r == 5, 1'b0);
        idle(1);
        chk("short_err", err, 1'b1);
        nb = nbeats;
        wait_drain("short", 40);
        chk("short_beats", nbeats - nb, 8);
        do_reset();

        // Ninth row without eob is dropped
        for (int r = 0; r < 8; r++) send(mkrow(500, r), r == 0, 1'b0, 1'b0);
        send(mkrow(900, 0), 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("ovf_err", err, 1'b1);
        send(mkrow(500, 7), 1'b0, 1'b1, 1'b0);
        idle(1);
        wait_drain("ovf", 40);
        do_reset();

        // Reset in the middle of a drain
        send_block(1000, 1'b1);
        idle(1);
        w = 0;
        while (!(out_valid && out_sob) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_b0_seen", out_valid && out_sob, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_b3_valid", out_valid, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        b0q.delete();
        send_block(2000, 1'b1);
        t1 = eob_cyc;
        idle(1);
        wait_drain("post_rst", 40);
        chk("post_rst_lat", (b0q.size() > 0) ? b0q[0] - t1 : -1, 2);

        // Ten blocks with random input gaps
        nb = nbeats;
        for (int b = 0; b < 10; b++) begin
            for (int r = 0; r < 8; r++) begin
                if ($urandom_range(1) == 1) idle(1);
                send(mkrow(3000 + 64 * b, r), r == 0, r == 7, b == 0 && r == 0);
            end
        end
        idle(1);
        wait_drain("gaps", 400);
        chk("gaps_beats", nbeats - nb, 80);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
